// File: rtl/i2s_audio_out_if.sv
// Audio-side and I2S-pin signals of i2s_audio_out.
// master = the serialiser, slave = the audio source / DAC side.
interface i2s_audio_out_if;
    logic [15:0] audio_l;
    logic [15:0] audio_r;
    logic        sample_strobe;
    logic        i2s_bclk;
    logic        i2s_lrck;
    logic        i2s_din;

    modport master (
        input  audio_l, audio_r,
        output sample_strobe, i2s_bclk, i2s_lrck, i2s_din
    );

    modport slave (
        output audio_l, audio_r,
        input  sample_strobe, i2s_bclk, i2s_lrck, i2s_din
    );
endinterface

// File: rtl/i2s_audio_out.sv
// Stereo 16-bit to I2S serialiser. A phase accumulator sets the bit clock, so the
// average frame rate is exact; both channels are latched together once per frame.
module i2s_audio_out #(
    parameter int unsigned CLK_HZ      = 32000000,
    parameter int unsigned SAMPLE_RATE = 48000,
    parameter int unsigned SLOT_BITS   = 16,
    parameter int unsigned I2S_DELAY   = 1
) (
    input  logic            clk32,
    input  logic            reset_n,
    input  logic            enable,
    i2s_audio_out_if.master bus
);
    localparam logic [31:0] INC   = 32'(4 * SAMPLE_RATE * SLOT_BITS);
    localparam logic [31:0] LIMIT = 32'(CLK_HZ);
    localparam int FRAME = 2 * SLOT_BITS;
    localparam int PW    = $clog2(FRAME);
    localparam int KW    = PW + 1;
    localparam int IW    = $clog2(SLOT_BITS);
    localparam int PAD   = SLOT_BITS - 16;

    if (INC >= LIMIT) begin : g_inc_check
        $error("i2s_audio_out: 4*SAMPLE_RATE*SLOT_BITS must be below CLK_HZ");
    end
    if (SLOT_BITS < 16) begin : g_slot_check
        $error("i2s_audio_out: SLOT_BITS must be at least 16");
    end

    logic [31:0]    acc_reg, acc_next;
    logic           bclk_reg, bclk_next;
    logic [PW-1:0]  p_reg, p_next;
    logic           lrck_reg, lrck_next;
    logic           din_reg, din_next;
    logic           strobe_reg, strobe_next;
    logic [15:0]    hold_l_reg, hold_l_next;
    logic [15:0]    hold_r_reg, hold_r_next;

    logic [32:0]    acc_sum;
    logic           tick, fall, load, left_slot;
    logic [PW-1:0]  p_adv;
    logic [KW-1:0]  k_sum, k_new;
    logic [IW-1:0]  bit_idx;
    logic [SLOT_BITS-1:0] slot_l, slot_r;

    // Samples sit MSB-aligned in the slot; any extra slot bits below them read as 0.
    for (genvar gi = 0; gi < SLOT_BITS; gi++) begin : g_slot
        if (gi >= PAD) begin : g_data
            assign slot_l[gi] = hold_l_reg[gi - PAD];
            assign slot_r[gi] = hold_r_reg[gi - PAD];
        end else begin : g_pad
            assign slot_l[gi] = 1'b0;
            assign slot_r[gi] = 1'b0;
        end
    end

    always_comb begin
        acc_sum   = {1'b0, acc_reg} + {1'b0, INC};
        tick      = acc_sum >= {1'b0, LIMIT};
        fall      = tick && bclk_reg;
        p_adv     = (p_reg == PW'(FRAME - 1)) ? '0 : p_reg + PW'(1);
        // word index k = (p_adv - I2S_DELAY) mod FRAME, done as an add to stay unsigned
        k_sum     = {1'b0, p_adv} + KW'(FRAME - I2S_DELAY);
        k_new     = (k_sum >= KW'(FRAME)) ? k_sum - KW'(FRAME) : k_sum;
        left_slot = k_new < KW'(SLOT_BITS);
        bit_idx   = left_slot ? IW'(KW'(SLOT_BITS - 1) - k_new) : IW'(KW'(FRAME - 1) - k_new);
        load      = fall && (k_new == '0);

        acc_next    = acc_reg;
        bclk_next   = bclk_reg;
        p_next      = p_reg;
        lrck_next   = lrck_reg;
        din_next    = din_reg;
        strobe_next = 1'b0;
        hold_l_next = hold_l_reg;
        hold_r_next = hold_r_reg;

        if (!enable) begin
            acc_next    = '0;
            bclk_next   = 1'b0;
            p_next      = PW'(FRAME - 1);
            lrck_next   = 1'b0;
            din_next    = 1'b0;
            hold_l_next = '0;
            hold_r_next = '0;
        end else begin
            acc_next    = tick ? 32'(acc_sum - {1'b0, LIMIT}) : acc_sum[31:0];
            strobe_next = load;
            if (tick) begin
                bclk_next = !bclk_reg;
            end
            if (fall) begin
                p_next    = p_adv;
                lrck_next = p_adv >= PW'(SLOT_BITS);
                // at the load the MSB comes straight from the input, not the stale hold
                if (load) begin
                    din_next = bus.audio_l[15];
                end else begin
                    din_next = left_slot ? slot_l[bit_idx] : slot_r[bit_idx];
                end
            end
            if (load) begin
                hold_l_next = bus.audio_l;
                hold_r_next = bus.audio_r;
            end
        end
    end

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            acc_reg    <= '0;
            bclk_reg   <= 1'b0;
            p_reg      <= PW'(FRAME - 1);
            lrck_reg   <= 1'b0;
            din_reg    <= 1'b0;
            strobe_reg <= 1'b0;
            hold_l_reg <= '0;
            hold_r_reg <= '0;
        end else begin
            acc_reg    <= acc_next;
            bclk_reg   <= bclk_next;
            p_reg      <= p_next;
            lrck_reg   <= lrck_next;
            din_reg    <= din_next;
            strobe_reg <= strobe_next;
            hold_l_reg <= hold_l_next;
            hold_r_reg <= hold_r_next;
        end
    end

    assign bus.i2s_bclk      = bclk_reg;
    assign bus.i2s_lrck      = lrck_reg;
    assign bus.i2s_din       = din_reg;
    assign bus.sample_strobe = strobe_reg;
endmodule
